quad_encoder_emulator: RTL and testbench

QUAD_ENCODER_EMULATOR -- requirements
Module: quad_encoder_emulator

---
 rtl/quad_encoder_emulator.sv | 217 +++++++++++++++++++++
 tb/tb_quad_encoder_emulator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder / pushbutton emulator: plays CW/CCW detent sequences on A/B
// and short, long or double presses on PB, one command at a time.
module quad_encoder_emulator #(
    parameter int unsigned STEP_DIV     = 1000,
    parameter int unsigned PB_SHORT_CYC = 50000,
    parameter int unsigned PB_LONG_CYC  = 2000000,
    parameter int unsigned PB_GAP_CYC   = 20000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_arg,
    input  logic       abort,
    output logic       A,
    output logic       B,
    output logic       PB,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_STEP       = 3'd1,
        ST_PRESS_HI   = 3'd2,
        ST_PRESS_GAP  = 3'd3,
        ST_PRESS_HI2  = 3'd4,
        ST_PRESS_GAP2 = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    localparam logic [23:0] STEP_RELOAD = 24'(STEP_DIV - 32'd1);
    localparam logic [23:0] SHORT_LEN   = 24'(PB_SHORT_CYC);
    localparam logic [23:0] LONG_LEN    = 24'(PB_LONG_CYC);
    localparam logic [23:0] GAP_LEN     = 24'(PB_GAP_CYC);

    // Gray position 0..3 to (A,B); CW walks the position upward, CCW downward.
    function automatic logic [1:0] ab_of_pos(input logic [1:0] pos);
        logic [1:0] ab;
        case (pos)
            2'd0:    ab = 2'b11;
            2'd1:    ab = 2'b01;
            2'd2:    ab = 2'b00;
            2'd3:    ab = 2'b10;
            default: ab = 2'b11;
        endcase
        return ab;
    endfunction

    state_t      state_r, state_s;
    logic [23:0] timer_r, timer_s;
    logic [5:0]  cnt_r, cnt_s;
    logic [5:0]  tgt_r, tgt_s;
    logic [1:0]  pos_r, pos_s;
    logic        ccw_r, ccw_s;
    logic        dbl_r, dbl_s;
    logic        a_r, a_s;
    logic        b_r, b_s;
    logic        pb_r, pb_s;
    logic        busy_r;
    logic        done_r, done_s;
    logic        aborted_r, aborted_s;

    assign cmd_ready = (state_r == ST_IDLE);
    assign A         = a_r;
    assign B         = b_r;
    assign PB        = pb_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign aborted   = aborted_r;

    // Next-state, timer and output-level computation.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        cnt_s     = cnt_r;
        tgt_s     = tgt_r;
        pos_s     = pos_r;
        ccw_s     = ccw_r;
        dbl_s     = dbl_r;
        a_s       = a_r;
        b_s       = b_r;
        pb_s      = pb_r;
        done_s    = 1'b0;
        aborted_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    // Malformed commands run as a zero-length step: done one cycle later.
                    state_s = ST_STEP;
                    timer_s = 24'd0;
                    cnt_s   = 6'd0;
                    tgt_s   = 6'd0;
                    pos_s   = 2'd0;
                    ccw_s   = 1'b0;
                    dbl_s   = 1'b0;
                    case (cmd_op)
                        2'b00, 2'b01: begin
                            tgt_s = {cmd_arg, 2'b00};
                            ccw_s = cmd_op[0];
                        end
                        2'b10: begin
                            if ((cmd_arg[3:2] == 2'b00) && (cmd_arg[1:0] != 2'b00)) begin
                                state_s = ST_PRESS_HI;
                                timer_s = (cmd_arg[1:0] == 2'b10) ? LONG_LEN : SHORT_LEN;
                                dbl_s   = (cmd_arg[1:0] == 2'b11);
                            end else begin
                                state_s = ST_STEP;
                            end
                        end
                        default: state_s = ST_STEP;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (timer_r == 24'd0) begin
                    if (cnt_r == tgt_r) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        pos_s      = ccw_r ? (pos_r - 2'd1) : (pos_r + 2'd1);
                        {a_s, b_s} = ab_of_pos(pos_s);
                        cnt_s      = cnt_r + 6'd1;
                        timer_s    = STEP_RELOAD;
                    end
                end else begin
                    timer_s = timer_r - 24'd1;
                end
            end
            ST_PRESS_HI, ST_PRESS_HI2: begin
                pb_s = 1'b1;
                if (timer_r < 24'd2) begin
                    state_s = (state_r == ST_PRESS_HI) ? ST_PRESS_GAP : ST_PRESS_GAP2;
                    timer_s = GAP_LEN;
                end else begin
                    timer_s = timer_r - 24'd1;
                end
            end
            ST_PRESS_GAP, ST_PRESS_GAP2: begin
                pb_s = 1'b0;
                // The second pulse is entered a cycle early so PB rises right after the gap.
                if ((state_r == ST_PRESS_GAP) && dbl_r) begin
                    if (timer_r < 24'd2) begin
                        state_s = ST_PRESS_HI2;
                        timer_s = SHORT_LEN;
                    end else begin
                        timer_s = timer_r - 24'd1;
                    end
                end else if (timer_r == 24'd0) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else begin
                    timer_s = timer_r - 24'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (abort && (state_r != ST_IDLE) && (state_r != ST_DONE)) begin
            state_s   = ST_DONE;
            timer_s   = 24'd0;
            cnt_s     = 6'd0;
            pos_s     = 2'd0;
            a_s       = 1'b1;
            b_s       = 1'b1;
            pb_s      = 1'b0;
            done_s    = 1'b1;
            aborted_s = 1'b1;
        end else begin
            aborted_s = aborted_s;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            timer_r   <= 24'd0;
            cnt_r     <= 6'd0;
            tgt_r     <= 6'd0;
            pos_r     <= 2'd0;
            ccw_r     <= 1'b0;
            dbl_r     <= 1'b0;
            a_r       <= 1'b1;
            b_r       <= 1'b1;
            pb_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            cnt_r     <= cnt_s;
            tgt_r     <= tgt_s;
            pos_r     <= pos_s;
            ccw_r     <= ccw_s;
            dbl_r     <= dbl_s;
            a_r       <= a_s;
            b_r       <= b_s;
            pb_r      <= pb_s;
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= done_s;
            aborted_r <= aborted_s;
        end
    end

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Bench for quad_encoder_emulator: directed and random commands compared cycle by
// cycle against a timeline model derived from the command's phase durations.
module tb_quad_encoder_emulator;

    localparam int SD = 4;
    localparam int PS = 8;
    localparam int PL = 20;
    localparam int PG = 6;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_arg;
    logic       abort;
    logic       A, B, PB, busy, done, aborted;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    quad_encoder_emulator #(
        .STEP_DIV(SD), .PB_SHORT_CYC(PS), .PB_LONG_CYC(PL), .PB_GAP_CYC(PG)
    ) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort),
        .A(A), .B(B), .PB(PB), .busy(busy), .done(done), .aborted(aborted)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b (A,B,PB,busy,done,aborted,ready)", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {A, B, PB, busy, done, aborted, cmd_ready};
    endfunction

    // Cycle (after accept) on which done is expected for an unaborted command.
    function automatic int model_tdone(input logic [1:0] op, input logic [3:0] arg);
        if (op == 2'b00 || op == 2'b01) return 1 + 4 * int'(arg) * SD;
        if (op == 2'b10 && arg[3:2] == 2'b00) begin
            if (arg[1:0] == 2'b01) return 1 + PS + PG;
            if (arg[1:0] == 2'b10) return 1 + PL + PG;
            if (arg[1:0] == 2'b11) return 1 + 2 * (PS + PG);
        end
        return 1;
    endfunction

    // Expected {A,B,PB,busy,done,aborted,cmd_ready} t cycles after accept (abort sampled at ab_t).
    function automatic logic [6:0] model_out(input logic [1:0] op, input logic [3:0] arg,
                                             input int t, input int ab_t);
        logic [1:0] cw_seq[4];
        logic [1:0] ccw_seq[4];
        logic [1:0] ab;
        logic       pb;
        int         td, k, hl;
        cw_seq  = '{2'b11, 2'b01, 2'b00, 2'b10};
        ccw_seq = '{2'b11, 2'b10, 2'b00, 2'b01};
        td = model_tdone(op, arg);
        if (ab_t >= 1 && ab_t <= td) begin
            if (t == ab_t) return 7'b1101110;
            if (t > ab_t)  return 7'b1100001;
        end
        if (t == 0)  return 7'b1101000;
        if (t > td)  return 7'b1100001;
        if (t == td) return 7'b1101100;
        ab = 2'b11;
        pb = 1'b0;
        if (op[1] == 1'b0) begin
            k  = (t - 1) / SD + 1;
            ab = op[0] ? ccw_seq[k % 4] : cw_seq[k % 4];
        end else begin
            hl = (arg[1:0] == 2'b10) ? PL : PS;
            pb = (t <= hl) || (arg[1:0] == 2'b11 && t >= 1 + PS + PG && t <= 2 * PS + PG);
        end
        return {ab, pb, 1'b1, 1'b0, 1'b0, 1'b0};
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] arg, input int ab_t, input bit hold);
        int td, tend;
        td   = model_tdone(op, arg);
        tend = (ab_t >= 1 && ab_t <= td) ? ab_t : td;
        @(negedge clk);
        check_eq("ready_before_accept", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        abort     = (ab_t == 0);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check_eq($sformatf("op%0d_arg%0d_t0", op, arg), 32'(outs()), 32'(model_out(op, arg, 0, ab_t)));
        for (int t = 1; t <= tend + 1; t++) begin
            abort = (t == ab_t);
            if (!hold) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_arg   = 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("op%0d_arg%0d_ab%0d_t%0d", op, arg, ab_t, t),
                     32'(outs()), 32'(model_out(op, arg, t, ab_t)));
        end
        abort = 1'b0;
        if (hold) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_reaccept", 32'(outs()), 32'(model_out(op, arg, 0, -1)));
            cmd_valid = 1'b0;
            abort     = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_abort", 32'(outs()), 32'(7'b1101110));
            abort = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_idle", 32'(outs()), 32'(7'b1100001));
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    initial begin
        logic [1:0] rop;
        logic [3:0] rarg;
        int         rab, rtd;
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 4'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_state", 32'(outs()), 32'(7'b1100001));
        rstn = 1'b1;

        run_cmd(2'b00, 4'd1, -1, 1'b0);
        run_cmd(2'b01, 4'd2, -1, 1'b0);
        run_cmd(2'b10, 4'd3, -1, 1'b0);
        run_cmd(2'b00, 4'd3, 11, 1'b0);
        run_cmd(2'b00, 4'd0, -1, 1'b0);
        run_cmd(2'b10, 4'd0, -1, 1'b0);
        run_cmd(2'b10, 4'b0101, -1, 1'b0);
        run_cmd(2'b11, 4'd5, -1, 1'b0);
        run_cmd(2'b10, 4'd2, 0, 1'b0);
        run_cmd(2'b10, 4'd1, 12, 1'b0);
        run_cmd(2'b00, 4'd1, 17, 1'b0);
        run_cmd(2'b00, 4'd1, 18, 1'b0);
        run_cmd(2'b01, 4'd15, -1, 1'b0);
        run_cmd(2'b00, 4'd1, -1, 1'b1);

        // Reset in the middle of a long press.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_arg   = 4'd2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("long_pre_reset_t%0d", t), 32'(outs()), 32'(model_out(2'b10, 4'd2, t, -1)));
        end
        rstn = 1'b0;
        #1;
        check_eq("reset_midop", 32'(outs()), 32'(7'b1100001));
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("post_reset_idle", 32'(outs()), 32'(7'b1100001));
        end
        run_cmd(2'b10, 4'd1, -1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rarg = 4'($urandom_range(0, 15));
            rtd  = model_tdone(rop, rarg);
            rab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rtd + 1)) : -1;
            run_cmd(rop, rarg, rab, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
